// File: rtl/excess3_pkg.sv
// Shared types and constants for the Excess-3 coding blocks.
// ex3_width() gives the smallest result width that holds every DIGITS-digit value.
package excess3_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } ex3_state_e;

    localparam logic [3:0] EX3_OFFSET = 4'd3;
    localparam logic [3:0] EX3_MIN    = 4'd3;
    localparam logic [3:0] EX3_MAX    = 4'd12;

    // ceil(log2(10^digits)): bits needed for values 0 .. 10^digits-1.
    function automatic int ex3_width(input int digits);
        longint unsigned pow10;
        int              w;
        pow10 = 1;
        for (int i = 0; i < digits; i++) begin
            pow10 = pow10 * 10;
        end
        w = 0;
        while ((longint'(1) << w) < pow10) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/excess3_digit_decode.sv
// Combinational Excess-3 digit decoder: 4-bit code to digit value plus illegal flag.
// Illegal codes decode to value 0 so downstream arithmetic stays well-defined.
module excess3_digit_decode
    import excess3_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [3:0] digit_o,
    output logic       illegal_o
);

    // NOTE: every output gets a default first so no path through the block leaves a latch.
    always_comb begin
        digit_o   = 4'd0;
        illegal_o = 1'b1;
        if (code_i >= EX3_MIN && code_i <= EX3_MAX) begin
            digit_o   = code_i - EX3_OFFSET;
            illegal_o = 1'b0;
        end
    end

endmodule

// File: rtl/excess3_to_binary_serial.sv
// Digit-serial Excess-3 to binary converter: MSD first, acc = acc*10 + d per accepted digit.
// Result and sticky error are held in DONE until the consumer handshakes.
module excess3_to_binary_serial
    import excess3_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int OUT_W  = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_digit,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_bin,
    output logic             out_err
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

    if (DIGITS < 1) begin : g_bad_digits
        $error("excess3_to_binary_serial: DIGITS must be at least 1");
    end
    if (OUT_W < ex3_width(DIGITS)) begin : g_bad_width
        $error("excess3_to_binary_serial: OUT_W too small for DIGITS");
    end

    ex3_state_e       state_q;
    logic [OUT_W-1:0] acc_q;
    logic [OUT_W-1:0] acc_d;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    logic [3:0]       dec_digit;
    logic             dec_illegal;
    logic [OUT_W+3:0] acc_ext;
    logic [OUT_W+3:0] acc_wide;
    logic             accept;
    logic             frame_end;

    excess3_digit_decode u_decode (
        .code_i   (in_digit),
        .digit_o  (dec_digit),
        .illegal_o(dec_illegal)
    );

    // Multiply by ten as shift-and-add, with 4 guard bits before truncation.
    assign acc_ext  = {4'b0000, acc_q};
    assign acc_wide = (acc_ext << 3) + (acc_ext << 1) + (OUT_W + 4)'(dec_digit);
    assign acc_d    = OUT_W'(acc_wide);

    assign accept    = in_valid && (state_q == ACCUM);
    assign frame_end = in_last || (cnt_q == CNT_LAST);

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        acc_q <= acc_d;
                        err_q <= err_q | dec_illegal;
                        if (frame_end) begin
                            state_q <= DONE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= ACCUM;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    // Handshake flags come straight from the state register: no input-to-output paths.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign out_bin   = acc_q;
    assign out_err   = err_q;

endmodule

// File: doc/excess3_to_binary_serial.md
# excess3_to_binary_serial

Serial multi-digit Excess-3 to binary converter, the decode-side counterpart of the team's binary-to-Excess-3 encoders. It accepts one Excess-3 digit per handshake, most significant digit first, and accumulates `value = value*10 + (digit-3)`. After the last digit it presents the binary result with an error flag on a valid/ready output. It sits between a digit-serial Excess-3 source (display/keypad/link path) and binary arithmetic blocks.

## Interface
- `DIGITS`, default 4: maximum digits per frame.
- `OUT_W`, default 14: result width. Must be ≥ ceil(log2(10^DIGITS)). Elaboration fails otherwise.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `in_valid` input 1: `in_digit`/`in_last` are valid.
- `in_ready` output 1: converter can accept a digit.
- `in_digit` input 4: Excess-3 coded digit. Legal codes are 3..12.
- `in_last` input 1: marks the final digit of the frame.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer accepts the result.
- `out_bin` output OUT_W: binary result.
- `out_err` output 1: at least one illegal digit was seen in the frame.

## Operation
- States:
  - ACCUM: accepting digits. `in_ready`=1.
  - DONE: holding the result. `in_ready`=0, `out_valid`=1.
- Digit accepted on a rising edge with `in_valid && in_ready`.
- Digit decode:
  - Legal code (3..12): value d = code-3.
  - Illegal code (0,1,2,13,14,15): d = 0 and the sticky `err` is set for the frame.
- Accumulate: `acc <= acc*10 + d`. Compute at OUT_W+4 bits, then truncate to OUT_W. With the legal OUT_W there is no truncation loss.
- Digit counter `cnt` (0..DIGITS-1) increments per accepted digit.
- ACCUM -> DONE on the accepting edge when `in_last`=1 or `cnt`==DIGITS-1 (forced end; extra digits are never absorbed).
- DONE -> ACCUM on the edge with `out_valid && out_ready`. On that edge `acc`, `cnt` and `err` clear to 0.
- `out_bin` = `acc` and `out_err` = `err` at all times. They are only meaningful while `out_valid`=1, and are held stable throughout DONE.
- Single-digit frame (`in_last` on the first digit) is legal. Result = d.
- `in_last` with an illegal digit: frame ends normally with `out_err`=1.

## Timing
- Reset (async assert, sync release on the next `clk`): state ACCUM, `acc`=0, `cnt`=0, `err`=0. Outputs: `in_ready`=1, `out_valid`=0, `out_bin`=0, `out_err`=0.
- Throughput: one digit per cycle in ACCUM, with no bubbles between digits.
- Latency: `out_valid` rises 1 cycle after the accepting edge of the final digit.
- `in_ready` and `out_valid` are decoded directly from the state register, with no combinational path from the inputs.
- After the output handshake, `in_ready`=1 in the next cycle. Minimum frame period is N+1 cycles for N digits.
- `out_ready` is ignored outside DONE. `in_valid` is ignored in DONE.
- Reset asserted mid-frame or in DONE: the partial frame and any pending result are discarded immediately. No output is produced for that frame.

## Structure
- Package `excess3_pkg`:
  - state enum {ACCUM, DONE}
  - constants `EX3_OFFSET`=3, `EX3_MIN`=3, `EX3_MAX`=12
  - function `ex3_width(digits)` returning the required OUT_W.
- Sub-module `excess3_digit_decode`: combinational, 4-bit code -> 4-bit digit value plus `illegal` flag. It is reusable by the other Excess-3 blocks.
- Top module: FSM, digit counter, accumulator (multiply by 10 as `(acc<<3)+(acc<<1)`).

## Test plan
- Digits 4,5,6,7 (last on 7), `out_ready`=1 -> `out_valid` one cycle after 7 is accepted; `out_bin`=1234, `out_err`=0.
- Digits C,C,C,C with no `in_last` -> forced end after the 4th digit; `out_bin`=9999 (0x270F), `out_err`=0; `in_ready` low during DONE.
- Digits 8,3 with last on 3 -> `out_bin`=50; the next frame, digit 4 with last, -> `out_bin`=1 (`acc` was cleared).
- Digits 4,F,5 (last) -> `out_bin`=102 (F treated as 0), `out_err`=1. The following clean frame 6 (last) -> `out_bin`=3, `out_err`=0.
- Frame 7,7 (last), `out_ready` held low 5 cycles -> `out_valid`=1, `out_bin`=44 stable; `in_ready`=0 and `in_valid` pulses are ignored; handshake on cycle 6, `in_ready`=1 the next cycle.
- Digits 5,6 then `rst` pulse mid-cycle -> all outputs return to reset values asynchronously. A new frame 9 (last) -> `out_bin`=6.
